// File: rtl/alu_exec_stage_pkg.sv
// Shared opcode/condition constants and opcode-class predicates
// for the ALU execute stage.
package alu_exec_stage_pkg;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_XOR    = 4'h2;
  localparam logic [3:0] OP_RED    = 4'h3;
  localparam logic [3:0] OP_SLL    = 4'h4;
  localparam logic [3:0] OP_SRA    = 4'h5;
  localparam logic [3:0] OP_ROR    = 4'h6;
  localparam logic [3:0] OP_PADDSB = 4'h7;
  localparam logic [3:0] OP_LLB    = 4'h8;
  localparam logic [3:0] OP_LHB    = 4'h9;

  localparam logic [2:0] CC_NE     = 3'b000;
  localparam logic [2:0] CC_EQ     = 3'b001;
  localparam logic [2:0] CC_GT     = 3'b010;
  localparam logic [2:0] CC_LT     = 3'b011;
  localparam logic [2:0] CC_GE     = 3'b100;
  localparam logic [2:0] CC_LE     = 3'b101;
  localparam logic [2:0] CC_OV     = 3'b110;
  localparam logic [2:0] CC_UNCOND = 3'b111;

  function automatic logic op_legal(
    input logic [3:0] op
  );
    return op <= OP_LHB;
  endfunction

  function automatic logic op_sets_all_flags(
    input logic [3:0] op
  );
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  function automatic logic op_sets_z(
    input logic [3:0] op
  );
    return (op == OP_ADD) || (op == OP_SUB)
        || (op == OP_XOR) || (op == OP_SLL)
        || (op == OP_SRA) || (op == OP_ROR);
  endfunction

  function automatic logic op_is_shift(
    input logic [3:0] op
  );
    return (op == OP_SLL) || (op == OP_SRA)
        || (op == OP_ROR);
  endfunction

  function automatic logic op_is_byte(
    input logic [3:0] op
  );
    return (op == OP_LLB) || (op == OP_LHB);
  endfunction

endpackage

// File: rtl/alu.sv
// 16-bit ALU: add/sub with signed-overflow err, xor, byte
// reduction, shifts/rotate, nibble-saturating add, byte loads.
module alu
  import alu_exec_stage_pkg::*;
(
  input  logic [15:0] aluin1,
  input  logic [15:0] aluin2,
  input  logic [3:0]  aluop,
  output logic [15:0] aluout,
  output logic        err
);

  logic [16:0] sum;
  logic [16:0] dif;
  logic [31:0] rot;
  logic [4:0]  nib;

  assign sum = {aluin1[15], aluin1} + {aluin2[15], aluin2};
  assign dif = {aluin1[15], aluin1} - {aluin2[15], aluin2};
  assign rot = {aluin1, aluin1} >> aluin2[3:0];

  always_comb begin
    aluout = '0;
    err    = 1'b0;
    nib    = '0;
    case (aluop)
      OP_ADD: begin
        aluout = sum[15:0];
        err    = sum[16] ^ sum[15];
      end
      OP_SUB: begin
        aluout = dif[15:0];
        err    = dif[16] ^ dif[15];
      end
      OP_XOR: aluout = aluin1 ^ aluin2;
      OP_RED: aluout =
          {{8{aluin1[15]}}, aluin1[15:8]}
        + {{8{aluin1[7]}},  aluin1[7:0]}
        + {{8{aluin2[15]}}, aluin2[15:8]}
        + {{8{aluin2[7]}},  aluin2[7:0]};
      OP_SLL: aluout = aluin1 << aluin2[3:0];
      OP_SRA: aluout = $signed(aluin1) >>> aluin2[3:0];
      OP_ROR: aluout = rot[15:0];
      OP_PADDSB: begin
        for (int i = 0; i < 4; i++) begin
          nib = {aluin1[4*i+3], aluin1[4*i +: 4]}
              + {aluin2[4*i+3], aluin2[4*i +: 4]};
          // sign disagreement between bits 4 and 3
          // means the nibble sum overflowed
          if (nib[4] ^ nib[3])
            aluout[4*i +: 4] = nib[4] ? 4'h8 : 4'h7;
          else
            aluout[4*i +: 4] = nib[3:0];
        end
      end
      OP_LLB: aluout = {aluin1[15:8], aluin2[7:0]};
      OP_LHB: aluout = {aluin2[7:0], aluin1[7:0]};
      default: aluout = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec_stage_flags.sv
// Z/V/N flag register with per-opcode update and branch decode.
// upd marks an accepted op; br_taken is combinational.
module alu_flag_reg
  import alu_exec_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        upd,
  input  logic [3:0]  op,
  input  logic [15:0] res,
  input  logic        err,
  input  logic [2:0]  br_cond,
  output logic        flag_z,
  output logic        flag_v,
  output logic        flag_n,
  output logic        br_taken
);

  always_ff @(posedge clk) begin
    if (rst) begin
      flag_z <= 1'b0;
      flag_v <= 1'b0;
      flag_n <= 1'b0;
    end else if (upd) begin
      if (op_sets_z(op))
        flag_z <= (res == '0);
      if (op_sets_all_flags(op)) begin
        flag_n <= res[15];
        flag_v <= err;
      end
    end
  end

  always_comb begin
    br_taken = 1'b0;
    unique case (br_cond)
      CC_NE:     br_taken = !flag_z;
      CC_EQ:     br_taken = flag_z;
      CC_GT:     br_taken = !flag_z && !flag_n;
      CC_LT:     br_taken = flag_n;
      CC_GE:     br_taken = flag_z || !flag_n;
      CC_LE:     br_taken = flag_n || flag_z;
      CC_OV:     br_taken = flag_v;
      CC_UNCOND: br_taken = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage: operand mux, alu, one-entry result slot with
// valid/ready backpressure, and the Z/V/N flag register.
module alu_exec_stage
  import alu_exec_stage_pkg::*;
#(
  parameter int DW = 16,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_op,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_b,
  input  logic [7:0]    in_imm,
  input  logic [RW-1:0] in_rd,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_result,
  output logic [RW-1:0] out_rd,
  output logic          out_err,
  output logic          flag_z,
  output logic          flag_v,
  output logic          flag_n,
  input  logic [2:0]    br_cond,
  output logic          br_taken
);

  logic          accept;
  logic          legal;
  logic [DW-1:0] aluin2;
  logic [DW-1:0] aluout;
  logic          alu_err;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign legal    = op_legal(in_op);

  always_comb begin
    aluin2 = in_b;
    unique case (1'b1)
      op_is_shift(in_op): aluin2 = {12'b0, in_imm[3:0]};
      op_is_byte(in_op):  aluin2 = {8'b0, in_imm};
      default:            aluin2 = in_b;
    endcase
  end

  alu u_alu (
    .aluin1 (in_a),
    .aluin2 (aluin2),
    .aluop  (in_op),
    .aluout (aluout),
    .err    (alu_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_rd     <= '0;
      out_err    <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_result <= legal ? aluout : '0;
      out_rd     <= in_rd;
      out_err    <= !legal || alu_err;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  alu_flag_reg u_flags (
    .clk      (clk),
    .rst      (rst),
    .upd      (accept),
    .op       (in_op),
    .res      (aluout),
    .err      (alu_err),
    .br_cond  (br_cond),
    .flag_z   (flag_z),
    .flag_v   (flag_v),
    .flag_n   (flag_n),
    .br_taken (br_taken)
  );

endmodule

// File: tb/tb_alu_exec_stage.sv
// Randomized bench for alu_exec_stage against an arithmetic
// reference model of the slot, flags and branch conditions.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [7:0]  in_imm;
  logic [3:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [3:0]  out_rd;
  logic        out_err;
  logic        flag_z;
  logic        flag_v;
  logic        flag_n;
  logic [2:0]  br_cond;
  logic        br_taken;

  int total = 0;
  int bad   = 0;

  logic        m_valid = 1'b0;
  logic [15:0] m_res   = '0;
  logic [3:0]  m_rd    = '0;
  logic        m_err   = 1'b0;
  logic        mz = 1'b0;
  logic        mv = 1'b0;
  logic        mn = 1'b0;

  always #5 clk = ~clk;

  alu_exec_stage #(.DW(16), .RW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_imm     (in_imm),
    .in_rd      (in_rd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd),
    .out_err    (out_err),
    .flag_z     (flag_z),
    .flag_v     (flag_v),
    .flag_n     (flag_n),
    .br_cond    (br_cond),
    .br_taken   (br_taken)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int sx4(input int v);
    return (v > 7) ? v - 16 : v;
  endfunction

  function automatic int sx8(input logic [7:0] v);
    int x;
    x = v;
    return (x > 127) ? x - 256 : x;
  endfunction

  task automatic ref_alu(
    input  logic [3:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [7:0]  imm,
    output logic [15:0] r,
    output logic        e
  );
    int sa, sb, s, u, sh, acc;
    sa = $signed(a);
    sb = $signed(b);
    u  = a;
    sh = imm % 16;
    e  = 1'b0;
    r  = '0;
    case (op)
      4'h0, 4'h1: begin
        s = (op == 4'h0) ? sa + sb : sa - sb;
        r = s[15:0];
        e = (s > 32767) || (s < -32768);
      end
      4'h2: r = a ^ b;
      4'h3: begin
        s = sx8(a[15:8]) + sx8(a[7:0])
          + sx8(b[15:8]) + sx8(b[7:0]);
        r = s[15:0];
      end
      4'h4: begin
        s = (u * (1 << sh)) % 65536;
        r = s[15:0];
      end
      4'h5: begin
        s = sa;
        for (int k = 0; k < sh; k++)
          s = (s < 0) ? -((-s + 1) / 2) : s / 2;
        r = s[15:0];
      end
      4'h6: begin
        s = (u >> sh) | ((u << (16 - sh)) % 65536);
        r = s[15:0];
      end
      4'h7: begin
        acc = 0;
        for (int k = 0; k < 4; k++) begin
          s = sx4((u >> (4 * k)) % 16)
            + sx4((b >> (4 * k)) % 16);
          if (s > 7)  s = 7;
          if (s < -8) s = -8;
          acc += ((s + 16) % 16) << (4 * k);
        end
        r = acc[15:0];
      end
      4'h8: r = (a & 16'hff00) | {8'h00, imm};
      4'h9: r = (a & 16'h00ff) | {imm, 8'h00};
      default: begin
        r = '0;
        e = 1'b1;
      end
    endcase
  endtask

  function automatic logic ref_br(input logic [2:0] c);
    case (c)
      3'd0: return !mz;
      3'd1: return mz;
      3'd2: return !mz && !mn;
      3'd3: return mn;
      3'd4: return mz || (!mz && !mn);
      3'd5: return mn || mz;
      3'd6: return mv;
      default: return 1'b1;
    endcase
  endfunction

  task automatic step();
    logic [15:0] r;
    logic        e;
    logic        rdy;
    @(negedge clk);
    rdy = !m_valid || out_ready;
    chk("in_ready", in_ready, rdy);
    chk("out_valid", out_valid, m_valid);
    chk("result", out_result, m_res);
    chk("rd", out_rd, m_rd);
    chk("err", out_err, m_err);
    chk("flags", {flag_z, flag_v, flag_n}, {mz, mv, mn});
    chk("br_taken", br_taken, ref_br(br_cond));
    if (rst) begin
      m_valid = 0; m_res = 0; m_rd = 0; m_err = 0;
      mz = 0; mv = 0; mn = 0;
    end else if (in_valid && rdy) begin
      ref_alu(in_op, in_a, in_b, in_imm, r, e);
      m_valid = 1; m_res = r; m_rd = in_rd; m_err = e;
      if (in_op == 0 || in_op == 1) begin
        mz = (r == 0); mn = r[15]; mv = e;
      end else if (in_op == 2 || in_op == 4
                || in_op == 5 || in_op == 6) begin
        mz = (r == 0);
      end
    end else if (out_ready) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(
    input logic [3:0]  op,
    input logic [15:0] a,
    input logic [15:0] b,
    input logic [7:0]  imm,
    input logic [3:0]  rd
  );
    in_op = op; in_a = a; in_b = b;
    in_imm = imm; in_rd = rd;
  endtask

  task automatic send(
    input logic [3:0]  op,
    input logic [15:0] a,
    input logic [15:0] b,
    input logic [7:0]  imm,
    input logic [3:0]  rd
  );
    drive(op, a, b, imm, rd);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    br_cond = 3'd0;
    drive(4'h0, 16'h1234, 16'h0001, 8'h00, 4'h3);
    @(posedge clk);
    #1;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    step();

    send(4'h0, 16'h0003, 16'h0004, 8'h00, 4'h2);
    chk("add_res", out_result, 32'h0007);
    chk("add_rd", out_rd, 32'h2);
    chk("add_flags", {flag_z, flag_v, flag_n}, 32'h0);

    send(4'h1, 16'h0005, 16'h0005, 8'h00, 4'h1);
    br_cond = 3'b001;
    chk("sub_res", out_result, 32'h0);
    chk("sub_z", flag_z, 32'h1);
    chk("eq_taken", br_taken, 32'h1);
    send(4'h2, 16'hde15, 16'h3f3d, 8'h00, 4'h4);
    chk("xor_res", out_result, 32'he128);
    chk("xor_flags", {flag_z, flag_v, flag_n}, 32'h0);

    send(4'h8, 16'h1111, 16'h0, 8'h88, 4'h5);
    chk("llb_res", out_result, 32'h1188);
    send(4'h9, 16'h1111, 16'h0, 8'h88, 4'h5);
    chk("lhb_res", out_result, 32'h8811);
    send(4'h6, 16'h2222, 16'h0, 8'h05, 4'h6);
    chk("ror_res", out_result, 32'h1111);
    step();

    out_ready = 1'b0;
    send(4'h0, 16'h0010, 16'h0020, 8'h00, 4'h7);
    drive(4'h1, 16'h0040, 16'h0001, 8'h00, 4'h8);
    in_valid = 1'b1;
    repeat (3) begin
      step();
      chk("bp_hold", out_result, 32'h0030);
    end
    out_ready = 1'b1;
    step();
    chk("bp_next", out_result, 32'h003f);
    send(4'h2, 16'h00ff, 16'h000f, 8'h00, 4'h9);
    chk("b2b_valid", out_valid, 32'h1);

    send(4'hc, 16'h1234, 16'h5678, 8'h00, 4'ha);
    chk("ill_err", out_err, 32'h1);
    chk("ill_res", out_result, 32'h0);
    send(4'h1, 16'h8000, 16'h0001, 8'h00, 4'hb);
    br_cond = 3'b110;
    chk("ovf_err", out_err, 32'h1);
    chk("ovf_taken", br_taken, 32'h1);
    step();

    send(4'h0, 16'h0001, 16'h0002, 8'h00, 4'hc);
    out_ready = 1'b0;
    in_valid = 1'b1;
    drive(4'h1, 16'h0009, 16'h0009, 8'h00, 4'hd);
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("rst_valid", out_valid, 32'h0);
    chk("rst_flags", {flag_z, flag_v, flag_n}, 32'h0);
    chk("rst_ready", in_ready, 32'h1);
    step();
    out_ready = 1'b1;

    for (int n = 0; n < 3000; n++) begin
      logic [15:0] a, b;
      a = 16'($urandom);
      b = 16'($urandom);
      if ($urandom_range(0, 7) == 0) b = a;
      if ($urandom_range(0, 7) == 0) a = 16'h8000;
      if ($urandom_range(0, 7) == 0) b = 16'h7fff;
      drive(4'($urandom_range(0, 15)), a, b,
            8'($urandom), 4'($urandom));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      br_cond   = 3'($urandom);
      rst       = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute stage that sits between the decoder and writeback, and is the consumer side of the ALU interface.
- Accepts decoded ALU operations over a valid/ready handshake, forms the operands, and drives one instance of the existing alu.
- Registers the result, destination and error into a single-entry output slot with backpressure.
- Maintains the Z/V/N flag register and evaluates branch conditions from it.

Parameters:
- DW, 16, datapath width (fixed by the ISA; kept only for readability)
- RW, 4, register-index width

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- in_valid  input  1  decoded operation present
- in_ready  output  1  stage can accept the operation this cycle
- in_op  input  4  ALU opcode: 0 ADD, 1 SUB, 2 XOR, 3 RED, 4 SLL, 5 SRA, 6 ROR, 7 PADDSB, 8 LLB, 9 LHB, A-F illegal
- in_a  input  DW  first operand (rs value; old rd value for LLB/LHB)
- in_b  input  DW  second operand (rt value)
- in_imm  input  8  immediate (imm[3:0] is the shift amount; imm[7:0] is the byte for LLB/LHB)
- in_rd  input  RW  destination register
- out_valid  output  1  result slot occupied
- out_ready  input  1  writeback consumes the slot
- out_result  output  DW  registered ALU result
- out_rd  output  RW  registered destination
- out_err  output  1  ALU err, or illegal opcode
- flag_z, flag_v, flag_n  output  1 each  flag register
- br_cond  input  3  branch condition code
- br_taken  output  1  condition true against the current flags

Behaviour:
- Accept rule: accept = in_valid && in_ready, with in_ready = !out_valid || out_ready. Accept and drain in the same cycle is allowed (full throughput).
- Operand mux into alu:
  - aluin1 = in_a for all opcodes.
  - aluin2 = in_b for ops 0-3 and 7.
  - aluin2 = {12'b0, imm[3:0]} for ops 4-6.
  - aluin2 = {8'b0, imm} for ops 8-9.
  - aluop = in_op.
- Output slot on the accept cycle: at the next edge out_result = aluout, out_rd = in_rd, out_err = err, out_valid = 1. Latency is one cycle.
- Illegal opcode (A-F): slot loads with out_result = 0 and out_err = 1; flags are unchanged.
- Draining without a new accept: out_valid goes to 0 at the edge; out_result, out_rd and out_err hold their last values.
- Holding: while out_valid && !out_ready, all out_* stay stable and in_ready = 0.
- Flag update rules, all on the accept edge, registered and visible the next cycle:
  - ADD, SUB: Z = (aluout == 0), N = aluout[15], V = err.
  - XOR, SLL, SRA, ROR: Z updated only; N and V hold.
  - RED, PADDSB, LLB, LHB, illegal: no flag change.
- br_taken is combinational from br_cond and the flag register:
  - 000 NE: !Z
  - 001 EQ: Z
  - 010 GT: !Z && !N
  - 011 LT: N
  - 100 GE: Z || (!Z && !N)
  - 101 LE: N || Z
  - 110 OV: V
  - 111 UNCOND: 1
- Same-cycle flag op and branch: a branch evaluated in the accept cycle of a flag-setting op sees the old flags. Hazard avoidance is the decoder's job.
- Reset: when rst = 1 at the edge, out_valid = 0, out_result = 0, out_rd = 0, out_err = 0, and Z = V = N = 0. Any pending slot is dropped. in_ready = 1 in the first cycle after reset.
- Reset mid-handshake: an operation presented together with rst is not accepted.

Decomposition:
- Shared package holds:
  - opcode constants OP_ADD..OP_LHB
  - branch-condition constants CC_NE..CC_UNCOND
  - helper predicates op_sets_all_flags and op_sets_z
- One sub-module, alu_flag_reg: the flag register plus update logic plus br_taken decode.
- The existing alu is instantiated unchanged.

Test Plan:
- ADD in_a=0003, in_b=0004, rd=2, out_ready=1 -> next cycle out_valid=1, result=0007, rd=2, err=0; flags Z=0 N=0 V=0.
- SUB in_a=in_b=0005, then br_cond=001 the following cycle -> result=0000, Z=1, br_taken=1. Then XOR de15^3f3d -> result=e128, Z=0, N still 0, V still 0.
- LLB in_a=1111 imm=88 -> 1188; LHB in_a=1111 imm=88 -> 8811; ROR in_a=2222 imm=5 -> 1111. Flags after LLB/LHB are unchanged from the prior op.
- Backpressure: out_ready=0 for 3 cycles with in_valid held -> in_ready=0, out_result stable. Release -> one-cycle drain and accept together, back-to-back results with no bubble.
- Illegal op 0xC -> out_err=1, result=0000, flags unchanged. SUB 8000-0001 -> err=1, V=1, br_cond=110 gives br_taken=1.
- Assert rst while out_valid=1 and in_valid=1 -> next cycle out_valid=0, flags 000, in_ready=1, and the presented op is not recorded.
